// File: rtl/xbee_pkg.sv
// Shared definitions for the XBee API-frame receiver: FSM states, framing
// constants and error codes.
package xbee_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN_MSB = 3'd1,
        LEN_LSB = 3'd2,
        DATA    = 3'd3,
        CSUM    = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam logic [7:0] START_DELIM = 8'h7E;
    localparam logic [7:0] CSUM_GOOD   = 8'hFF;

    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Modulo-256 running checksum step.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/xbee_frame_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, synchronous write,
// registered read. The storage itself is not reset; only the read register is.
module xbee_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_r [DEPTH];

    // Write port: store one payload byte per accepted data strobe.
    always_ff @(posedge clk) begin
        if (we && (32'(wr_addr) < DEPTH)) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: one-cycle registered read, out-of-range addresses read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= 8'h00;
        end else if (32'(rd_addr) < DEPTH) begin
            rd_data <= mem_r[rd_addr];
        end else begin
            rd_data <= 8'h00;
        end
    end

endmodule

// File: rtl/xbee_frame_ctrl.sv
// XBee API mode-1 frame sequencer: hunts for 0x7E, parses the 16-bit length,
// buffers the payload, verifies the checksum and holds the frame for the host.
module xbee_frame_ctrl
    import xbee_pkg::*;
#(
    parameter int MAX_PAYLOAD    = 16,
    parameter int TIMEOUT_CYCLES = 200_000,
    parameter int AW             = $clog2(MAX_PAYLOAD),
    parameter int LW             = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_ready,
    output logic          frame_valid,
    output logic [LW-1:0] frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          busy,
    output logic          err_pulse,
    output logic [1:0]    err_code
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_r, state_s;
    logic          rdy_r;
    logic [7:0]    len_msb_r, len_msb_s;
    logic [LW-1:0] len_r, len_s;
    logic [LW-1:0] idx_r, idx_s;
    logic [7:0]    csum_r, csum_s;
    logic [TW-1:0] tmo_r, tmo_s;
    logic          frame_valid_s;
    logic [LW-1:0] frame_len_s;
    logic          err_pulse_s;
    logic [1:0]    err_code_s;
    logic          busy_s;

    logic          byte_stb_s;
    logic          active_s;
    logic          tmo_hit_s;
    logic [15:0]   len_full_s;
    logic          wr_en_s;

    // rx_ready is a level; only its rising edge marks a new byte.
    assign byte_stb_s = rx_ready & ~rdy_r;
    assign active_s   = (state_r == LEN_MSB) || (state_r == LEN_LSB) ||
                        (state_r == DATA)    || (state_r == CSUM);
    assign tmo_hit_s  = active_s && (tmo_r == TMO_LAST);
    assign len_full_s = {len_msb_r, rx_data};
    assign wr_en_s    = (state_r == DATA) && byte_stb_s;

    // Next-state, datapath and error decode for the frame parser.
    always_comb begin
        state_s       = state_r;
        len_msb_s     = len_msb_r;
        len_s         = len_r;
        idx_s         = idx_r;
        csum_s        = csum_r;
        frame_valid_s = frame_valid;
        frame_len_s   = frame_len;
        err_pulse_s   = 1'b0;
        err_code_s    = err_code;

        case (state_r)
            HUNT: begin
                if (byte_stb_s && (rx_data == START_DELIM)) begin
                    state_s = LEN_MSB;
                end else begin
                    state_s = HUNT;
                end
            end
            LEN_MSB: begin
                if (byte_stb_s) begin
                    len_msb_s = rx_data;
                    state_s   = LEN_LSB;
                end else if (tmo_hit_s) begin
                    err_pulse_s = 1'b1;
                    err_code_s  = ERR_TIMEOUT;
                    state_s     = HUNT;
                end else begin
                    state_s = LEN_MSB;
                end
            end
            LEN_LSB: begin
                if (byte_stb_s) begin
                    if ((len_full_s == 16'd0) || (len_full_s > 16'(MAX_PAYLOAD))) begin
                        err_pulse_s = 1'b1;
                        err_code_s  = ERR_LEN;
                        state_s     = HUNT;
                    end else begin
                        len_s   = LW'(len_full_s);
                        csum_s  = 8'h00;
                        idx_s   = {LW{1'b0}};
                        state_s = DATA;
                    end
                end else if (tmo_hit_s) begin
                    err_pulse_s = 1'b1;
                    err_code_s  = ERR_TIMEOUT;
                    state_s     = HUNT;
                end else begin
                    state_s = LEN_LSB;
                end
            end
            DATA: begin
                // 0x7E in the payload is plain data; no escaping in API mode 1.
                if (byte_stb_s) begin
                    csum_s = csum_add(csum_r, rx_data);
                    idx_s  = idx_r + LW'(1);
                    if (idx_r == (len_r - LW'(1))) begin
                        state_s = CSUM;
                    end else begin
                        state_s = DATA;
                    end
                end else if (tmo_hit_s) begin
                    err_pulse_s = 1'b1;
                    err_code_s  = ERR_TIMEOUT;
                    state_s     = HUNT;
                end else begin
                    state_s = DATA;
                end
            end
            CSUM: begin
                if (byte_stb_s) begin
                    if (csum_add(csum_r, rx_data) == CSUM_GOOD) begin
                        frame_len_s   = len_r;
                        frame_valid_s = 1'b1;
                        state_s       = HOLD;
                    end else begin
                        err_pulse_s = 1'b1;
                        err_code_s  = ERR_CSUM;
                        state_s     = HUNT;
                    end
                end else if (tmo_hit_s) begin
                    err_pulse_s = 1'b1;
                    err_code_s  = ERR_TIMEOUT;
                    state_s     = HUNT;
                end else begin
                    state_s = CSUM;
                end
            end
            HOLD: begin
                // Any byte arriving while a frame is held is lost, even on the ack cycle.
                if (byte_stb_s) begin
                    err_pulse_s = 1'b1;
                    err_code_s  = ERR_OVERRUN;
                end else begin
                    err_pulse_s = 1'b0;
                end
                if (frame_ack) begin
                    frame_valid_s = 1'b0;
                    state_s       = HUNT;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s       = HUNT;
                frame_valid_s = 1'b0;
            end
        endcase

        // Inter-byte timer restarts on every byte and on every state change.
        if (byte_stb_s || (state_s != state_r) || !active_s) begin
            tmo_s = {TW{1'b0}};
        end else begin
            tmo_s = tmo_r + TW'(1);
        end

        busy_s = (state_s != HUNT) && (state_s != HOLD);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= HUNT;
            rdy_r       <= 1'b1;
            len_msb_r   <= 8'h00;
            len_r       <= {LW{1'b0}};
            idx_r       <= {LW{1'b0}};
            csum_r      <= 8'h00;
            tmo_r       <= {TW{1'b0}};
            frame_valid <= 1'b0;
            frame_len   <= {LW{1'b0}};
            err_pulse   <= 1'b0;
            err_code    <= 2'd0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            rdy_r       <= rx_ready;
            len_msb_r   <= len_msb_s;
            len_r       <= len_s;
            idx_r       <= idx_s;
            csum_r      <= csum_s;
            tmo_r       <= tmo_s;
            frame_valid <= frame_valid_s;
            frame_len   <= frame_len_s;
            err_pulse   <= err_pulse_s;
            err_code    <= err_code_s;
            busy        <= busy_s;
        end
    end

    xbee_frame_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en_s),
        .wr_addr (idx_r[AW-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: doc/xbee_frame_ctrl.md
Name: xbee_frame_ctrl

Overview:
- Sequences the XBee UART receiver's byte stream into validated XBee API frames (API mode 1, no escaping).
- Hunts for the start delimiter, parses the 16-bit length, buffers the payload and checks the checksum.
- Presents a complete frame to the host logic through a hold/acknowledge handshake and a random-access read port.
- Sits directly downstream of the UART receiver's RxData_out/RxData_ready outputs.

Parameters:
- MAX_PAYLOAD, 16: maximum frame-data bytes accepted; the buffer depth.
- TIMEOUT_CYCLES, 200_000: inter-byte timeout in clk cycles (2 ms at 100 MHz).
- AW, $clog2(MAX_PAYLOAD): read-address width.
- LW, $clog2(MAX_PAYLOAD+1): frame-length width.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from the receiver's RxData_out.
- rx_ready  in  1  receiver's RxData_ready. This is a level: it stays high until the next start bit.
- frame_valid  out  1  a validated frame is held in the buffer.
- frame_len  out  LW  payload byte count of the held frame.
- rd_addr  in  AW  payload read address.
- rd_data  out  8  payload byte at rd_addr, registered.
- frame_ack  in  1  single-cycle pulse that releases the held frame.
- busy  out  1  a frame is being parsed (state is not HUNT or HOLD).
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  error code, valid while err_pulse=1: 0 overrun, 1 bad length, 2 bad checksum, 3 timeout.

Behaviour:
Reset values:
- All outputs 0, state HUNT, counters 0.
- rdy_q (registered rx_ready) resets to 1, so a byte left pending in the receiver at reset is never accepted.

Byte acceptance:
- byte_stb = rx_ready & ~rdy_q (rising edge).
- rx_data is sampled in that same cycle.

States:
- HUNT: if byte_stb and rx_data==8'h7E, go to LEN_MSB. All other bytes are silently discarded.
- LEN_MSB: on byte_stb, store len[15:8] and go to LEN_LSB.
- LEN_LSB: on byte_stb, form len.
  - If len==0 or len>MAX_PAYLOAD: err_code=1, go to HUNT.
  - Otherwise clear csum and idx, go to DATA.
- DATA: on byte_stb, write buf[idx]=rx_data, csum+=rx_data (mod 256), idx++.
  - When idx reaches len-1 on that byte, go to CSUM.
  - 8'h7E inside the payload is ordinary data.
- CSUM: on byte_stb:
  - If (csum+rx_data)&8'hFF==8'hFF: frame_len=len, frame_valid=1, go to HOLD.
  - Otherwise err_code=2, go to HUNT.
- HOLD: frame_valid=1; buffer contents and frame_len are frozen.
  - frame_ack: clear frame_valid next cycle, go to HUNT.
  - byte_stb: byte is dropped, err_code=0 (overrun).
  - If frame_ack and byte_stb coincide: ack is honoured, byte is dropped, overrun is reported.

Timeout:
- Counter runs in LEN_MSB, LEN_LSB, DATA and CSUM only; it clears on every byte_stb and on state entry.
- Reaching TIMEOUT_CYCLES-1 gives err_code=3 and a return to HUNT.
- If byte_stb and timeout coincide, the byte wins and the counter clears.

Timing:
- err_pulse and err_code are registered and asserted the cycle after the offending byte or timeout.
- frame_valid rises the cycle after the checksum byte's byte_stb.
- rd_data = buf[rd_addr] with 1-cycle latency in every state. Contents are guaranteed only while frame_valid=1.

Reset mid-frame:
- Immediately returns to HUNT and clears frame_valid.
- No error pulse.
- Buffer contents are don't-care.

Decomposition:
- Package xbee_pkg holds:
  - the state encoding (HUNT, LEN_MSB, LEN_LSB, DATA, CSUM, HOLD);
  - START_DELIM=8'h7E and CSUM_GOOD=8'hFF;
  - the ERR_OVERRUN/ERR_LEN/ERR_CSUM/ERR_TIMEOUT codes.
- One sub-module, xbee_frame_buf: MAX_PAYLOAD x 8 simple dual-port RAM with synchronous write and registered read.
- FSM, length/index counters, checksum and timeout logic stay in xbee_frame_ctrl.

Test Plan:
- Good frame: bytes 7E 00 03 01 02 03 F9 -> frame_valid=1, frame_len=3; rd_addr 0,1,2 -> rd_data 01,02,03; frame_ack -> frame_valid=0.
- Bad checksum: 7E 00 03 01 02 03 F8 -> err_pulse with err_code=2, frame_valid stays 0, state HUNT. A following good frame is accepted.
- Bad length: 7E 00 11 (17 > 16) and 7E 00 00 -> err_code=1 each time; subsequent bytes are ignored until the next 7E.
- Timeout: 7E 00 then idle for TIMEOUT_CYCLES -> err_code=3, busy falls. A byte arriving exactly at the limit clears the counter and raises no error.
- Overrun: hold the good frame without ack, send 7E 00 01 AA 54 -> five err_code=0 pulses; rd_data still reads 01 02 03.
- Reset and level input: assert reset mid-DATA -> frame_valid=0, no err_pulse. With rx_ready held high across reset release, no byte is accepted until rx_ready toggles low then high.
